sump_command_decoder: RTL and testbench

- Host-to-device side of the SUMP link; the opposite direction of the metadata/ID transmit path.
- Consumes the byte stream from the UART receiver and classifies it into short (1-byte) and long (opcode + 4 data bytes) commands.
- Emits single-cycle control strobes and drives begin_meta_transmit/send_id directly into metadata_sender.
- Holds metadata requests while the sender reports meta_busy.

---
 rtl/sump_pkg.sv | 25 ++
 rtl/sump_meta_req_arbiter.sv | 70 +++++++
 rtl/sump_command_decoder.sv | 199 +++++++++++++++++++
 tb/tb_sump_command_decoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sump_pkg.sv
// Shared SUMP link definitions: opcodes, decoder state encoding and framing constants.
// Imported by sump_command_decoder, sump_meta_req_arbiter and metadata_sender.
package sump_pkg;

    localparam logic [7:0] OP_RESET = 8'h00;
    localparam logic [7:0] OP_RUN   = 8'h01;
    localparam logic [7:0] OP_ID    = 8'h02;
    localparam logic [7:0] OP_META  = 8'h04;
    localparam logic [7:0] OP_XON   = 8'h11;
    localparam logic [7:0] OP_XOFF  = 8'h13;

    localparam int LONG_DATA_BYTES   = 4;
    // Cycles a fresh metadata pulse blocks the next one unless busy shows up sooner.
    localparam int META_GUARD_CYCLES = 2;

    typedef enum logic {
        IDLE = 1'b0,
        LONG = 1'b1
    } state_t;

    function automatic logic is_long_opcode(input logic [7:0] b);
        return b[7];
    endfunction

endpackage

// File: rtl/sump_meta_req_arbiter.sv
// One-slot metadata request holder: issues begin/send_id pulses to metadata_sender,
// parks a request while the sender is busy and guards against back-to-back pulses.
module sump_meta_req_arbiter
    import sump_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_req,
    input  logic i_req_kind,
    input  logic i_clear,
    input  logic i_meta_busy,
    output logic o_begin_meta_transmit,
    output logic o_send_id
);

    logic       r_pulse;
    logic       r_send_id;
    logic       r_pending;
    logic       r_pend_kind;
    logic [1:0] r_guard;

    logic w_allow;
    logic w_issue_pend;
    logic w_issue_new;
    logic w_issue;
    logic w_issue_kind;
    logic w_park;

    // A parked request has priority; a new one arriving meanwhile is dropped.
    assign w_allow      = !i_meta_busy && (r_guard == 2'd0);
    assign w_issue_pend = r_pending && w_allow && !i_clear;
    assign w_issue_new  = i_req && !r_pending && w_allow;
    assign w_issue      = w_issue_pend || w_issue_new;
    assign w_issue_kind = w_issue_pend ? r_pend_kind : i_req_kind;
    assign w_park       = i_req && !r_pending && !w_allow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pulse     <= 1'b0;
            r_send_id   <= 1'b0;
            r_pending   <= 1'b0;
            r_pend_kind <= 1'b0;
            r_guard     <= 2'd0;
        end else begin
            r_pulse <= w_issue;
            if (w_issue) begin
                r_send_id <= w_issue_kind;
            end

            if (w_issue) begin
                r_guard <= 2'(META_GUARD_CYCLES);
            end else if (i_meta_busy) begin
                r_guard <= 2'd0;
            end else if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end

            if (i_clear || w_issue_pend) begin
                r_pending <= 1'b0;
            end else if (w_park) begin
                r_pending   <= 1'b1;
                r_pend_kind <= i_req_kind;
            end
        end
    end

    assign o_begin_meta_transmit = r_pulse;
    assign o_send_id             = r_send_id;

endmodule

// File: rtl/sump_command_decoder.sv
// SUMP host command decoder: splits the UART byte stream into short strobes and long
// (opcode + 4 data bytes) commands. Optional long-command timeout: SUMP_CMD_TIMEOUT_EN.
module sump_command_decoder
    import sump_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        meta_busy,
    output logic        begin_meta_transmit,
    output logic        send_id,
    output logic        arm,
    output logic        soft_reset,
    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_data,
    output logic        xoff,
    output logic        proto_error,
    output state_t      dbg_state
);

    // rx_valid is a one-cycle strobe with no back-pressure: every strobed byte is consumed.
    // meta_busy is the sender's level; requests wait on it rather than on a ready pulse.
    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_opcode;
    logic [23:0] r_shadow;
    logic        r_arm;
    logic        r_soft_reset;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_opcode;
    logic [31:0] r_cmd_data;
    logic        r_xoff;

    logic w_expire;
    logic w_short;
    logic w_long_start;
    logic w_long_byte;
    logic w_long_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // On timeout expiry the byte of the same cycle is treated as a fresh IDLE byte.
    always_comb begin
        w_state_next = r_state;
        w_short      = 1'b0;
        w_long_start = 1'b0;
        w_long_byte  = 1'b0;
        w_long_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (is_long_opcode(rx_data)) begin
                        w_state_next = LONG;
                        w_long_start = 1'b1;
                    end else begin
                        w_short = 1'b1;
                    end
                end
            end
            LONG: begin
                if (w_expire) begin
                    w_state_next = IDLE;
                    if (rx_valid) begin
                        if (is_long_opcode(rx_data)) begin
                            w_state_next = LONG;
                            w_long_start = 1'b1;
                        end else begin
                            w_short = 1'b1;
                        end
                    end
                end else if (rx_valid) begin
                    w_long_byte = 1'b1;
                    if (r_byte_cnt == 2'(LONG_DATA_BYTES - 1)) begin
                        w_long_done  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    logic w_op_reset;
    logic w_op_run;
    logic w_op_xon;
    logic w_op_xoff;
    logic w_req;
    logic w_req_kind;

    assign w_op_reset = w_short && (rx_data == OP_RESET);
    assign w_op_run   = w_short && (rx_data == OP_RUN);
    assign w_op_xon   = w_short && (rx_data == OP_XON);
    assign w_op_xoff  = w_short && (rx_data == OP_XOFF);
    assign w_req      = w_short && ((rx_data == OP_ID) || (rx_data == OP_META));
    assign w_req_kind = (rx_data == OP_ID);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte_cnt   <= 2'd0;
            r_opcode     <= 8'h00;
            r_shadow     <= 24'h0;
            r_arm        <= 1'b0;
            r_soft_reset <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_opcode <= 8'h00;
            r_cmd_data   <= 32'h0;
            r_xoff       <= 1'b0;
        end else begin
            r_arm        <= w_op_run;
            r_soft_reset <= w_op_reset;
            r_cmd_valid  <= w_long_done;
            if (w_op_xon) begin
                r_xoff <= 1'b0;
            end else if (w_op_xoff) begin
                r_xoff <= 1'b1;
            end

            if (w_long_start) begin
                r_opcode   <= rx_data;
                r_byte_cnt <= 2'd0;
            end else if (w_long_byte) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0:    r_shadow[7:0]   <= rx_data;
                    2'd1:    r_shadow[15:8]  <= rx_data;
                    2'd2:    r_shadow[23:16] <= rx_data;
                    default: r_shadow        <= r_shadow;
                endcase
            end

            if (w_long_done) begin
                r_cmd_opcode <= r_opcode;
                r_cmd_data   <= {rx_data, r_shadow};
            end
        end
    end

`ifdef SUMP_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_proto_error;

    assign w_expire = (r_state == LONG) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_proto_error <= 1'b0;
        end else begin
            r_proto_error <= w_expire;
            if ((r_state != LONG) || rx_valid || w_expire) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign proto_error = r_proto_error;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_expire         = 1'b0;
    assign proto_error      = 1'b0;
`endif

    sump_meta_req_arbiter u_meta_arb (
        .clock                 (clock),
        .reset                 (reset),
        .i_req                 (w_req),
        .i_req_kind            (w_req_kind),
        .i_clear               (w_op_reset),
        .i_meta_busy           (meta_busy),
        .o_begin_meta_transmit (begin_meta_transmit),
        .o_send_id             (send_id)
    );

    assign arm        = r_arm;
    assign soft_reset = r_soft_reset;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_opcode = r_cmd_opcode;
    assign cmd_data   = r_cmd_data;
    assign xoff       = r_xoff;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sump_command_decoder.sv
// Bench for sump_command_decoder: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model of the command protocol.
module tb_sump_command_decoder;
    import sump_pkg::*;

    localparam int TB_TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        meta_busy;
    logic        begin_meta_transmit;
    logic        send_id;
    logic        arm;
    logic        soft_reset;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        xoff;
    logic        proto_error;
    state_t      dbg_state;

    sump_command_decoder #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clock               (clock),
        .reset               (reset),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .meta_busy           (meta_busy),
        .begin_meta_transmit (begin_meta_transmit),
        .send_id             (send_id),
        .arm                 (arm),
        .soft_reset          (soft_reset),
        .cmd_valid           (cmd_valid),
        .cmd_opcode          (cmd_opcode),
        .cmd_data            (cmd_data),
        .xoff                (xoff),
        .proto_error         (proto_error),
        .dbg_state           (dbg_state)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state (protocol-level view).
    int         m_cyc = 0;
    logic       m_long;
    logic [7:0] m_op;
    logic [7:0] m_bytes[$];
    int         m_idle;
    logic       m_pending;
    logic       m_kind;
    int         m_last_issue;
    logic       m_busy_seen;

    logic        e_arm, e_soft, e_cmd_valid, e_begin, e_send_id, e_xoff, e_proto;
    logic [7:0]  e_cmd_op;
    logic [31:0] e_cmd_data;

    int n_begin, n_cmd_valid, n_soft, n_arm, n_proto;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, m_cyc);
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic b, input logic rst);
        logic req, kind, allow, issued;
        m_cyc++;
        e_arm = 0; e_soft = 0; e_cmd_valid = 0; e_begin = 0; e_proto = 0;
        if (rst) begin
            m_long = 0; m_op = 0; m_bytes.delete(); m_idle = 0;
            m_pending = 0; m_kind = 0; m_last_issue = -100; m_busy_seen = 0;
            e_cmd_op = 0; e_cmd_data = 0; e_xoff = 0; e_send_id = 0;
            return;
        end
        req = 0; kind = 0; issued = 0;
`ifdef SUMP_CMD_TIMEOUT_EN
        if (m_long && m_idle == TB_TIMEOUT) begin
            m_long = 0;
            e_proto = 1;
        end
`endif
        if (v) begin
            if (m_long) begin
                m_bytes.push_back(d);
                m_idle = 0;
                if (m_bytes.size() == 4) begin
                    m_long = 0;
                    e_cmd_valid = 1;
                    e_cmd_op = m_op;
                    e_cmd_data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                end
            end else if (d >= 8'h80) begin
                m_long = 1; m_op = d; m_bytes.delete(); m_idle = 0;
            end else begin
                case (d)
                    8'h00: begin e_soft = 1; m_pending = 0; end
                    8'h01: e_arm = 1;
                    8'h02: begin req = 1; kind = 1; end
                    8'h04: begin req = 1; kind = 0; end
                    8'h11: e_xoff = 0;
                    8'h13: e_xoff = 1;
                    default: ;
                endcase
            end
        end else if (m_long) begin
            m_idle++;
        end
        // Pulse allowed when sender idle and either 3+ cycles since last pulse or busy seen since.
        allow = !b && ((m_cyc - m_last_issue) >= 3 || m_busy_seen);
        if (m_pending && allow) begin
            issued = 1; e_send_id = m_kind; m_pending = 0;
        end else if (req && !m_pending) begin
            if (allow) begin
                issued = 1; e_send_id = kind;
            end else begin
                m_pending = 1; m_kind = kind;
            end
        end
        if (issued) begin
            e_begin = 1; m_last_issue = m_cyc; m_busy_seen = 0;
        end else if (b) begin
            m_busy_seen = 1;
        end
    endtask

    task automatic compare_all();
        check("arm", arm, e_arm);
        check("soft_reset", soft_reset, e_soft);
        check("cmd_valid", cmd_valid, e_cmd_valid);
        check("cmd_opcode", cmd_opcode, e_cmd_op);
        check("cmd_data", cmd_data, e_cmd_data);
        check("xoff", xoff, e_xoff);
        check("begin_meta", begin_meta_transmit, e_begin);
        check("send_id", send_id, e_send_id);
        check("proto_error", proto_error, e_proto);
        check("state_long", dbg_state == LONG, m_long);
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic b, input logic rst);
        reset = rst; rx_valid = v; rx_data = d; meta_busy = b;
        model_step(v, d, b, rst);
        @(posedge clock);
        #1;
        compare_all();
        if (begin_meta_transmit) n_begin++;
        if (cmd_valid) n_cmd_valid++;
        if (soft_reset) n_soft++;
        if (arm) n_arm++;
        if (proto_error) n_proto++;
    endtask

    task automatic clear_counts();
        n_begin = 0; n_cmd_valid = 0; n_soft = 0; n_arm = 0; n_proto = 0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       busy;
        logic       exp_arm;
        logic       exp_soft;
        logic       exp_begin;
        logic       exp_send_id;
        logic       exp_xoff;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] seq_c[5];
    logic [7:0] seq_d[5];
    logic [7:0] pick[6];

    initial begin
        tbl[0] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_c = '{8'hC0, 8'h78, 8'h56, 8'h34, 8'h12};
        seq_d = '{8'h81, 8'h00, 8'h02, 8'h04, 8'h00};
        pick  = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h11, 8'h13};
        clear_counts();

        // Reset state
        cycle(0, 8'h00, 0, 1);
        cycle(1, 8'h01, 0, 1);
        check("reset_cmd_data", cmd_data, 32'h0);
        check("reset_arm", arm, 1'b0);

        // Short-command vector table
        for (int i = 0; i < 8; i++) begin
            cycle(1, tbl[i].data, tbl[i].busy, 0);
            check("tbl_arm", arm, tbl[i].exp_arm);
            check("tbl_soft", soft_reset, tbl[i].exp_soft);
            check("tbl_begin", begin_meta_transmit, tbl[i].exp_begin);
            check("tbl_send_id", send_id, tbl[i].exp_send_id);
            check("tbl_xoff", xoff, tbl[i].exp_xoff);
            repeat (3) cycle(0, 8'h00, 0, 0);
        end

        // Metadata request parked behind busy; a second request meanwhile is dropped
        clear_counts();
        cycle(1, 8'h04, 1, 0);
        repeat (5) cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h02, 1, 0);
        repeat (13) cycle(0, 8'h00, 1, 0);
        check("busy_no_pulse", n_begin, 0);
        repeat (6) cycle(0, 8'h00, 0, 0);
        check("busy_one_pulse", n_begin, 1);
        check("busy_send_id", send_id, 1'b0);

        // Long command
        clear_counts();
        for (int i = 0; i < 5; i++) cycle(1, seq_c[i], 0, 0);
        check("long_valid_now", cmd_valid, 1'b1);
        repeat (2) cycle(0, 8'h00, 0, 0);
        check("long_valid_cnt", n_cmd_valid, 1);
        check("long_opcode", cmd_opcode, 8'hC0);
        check("long_data", cmd_data, 32'h12345678);

        // Short opcodes inside a long command are plain data
        clear_counts();
        for (int i = 0; i < 5; i++) cycle(1, seq_d[i], 0, 0);
        repeat (4) cycle(0, 8'h00, 0, 0);
        check("data_only", cmd_data, 32'h00040200);
        check("data_opcode", cmd_opcode, 8'h81);
        check("data_no_soft", n_soft, 0);
        check("data_no_begin", n_begin, 0);

        // xoff levels, then reset mid-long and recover
        cycle(1, 8'h13, 0, 0);
        check("xoff_set", xoff, 1'b1);
        cycle(1, 8'h11, 0, 0);
        check("xoff_clr", xoff, 1'b0);
        cycle(1, 8'hC0, 0, 0);
        cycle(1, 8'hAA, 0, 0);
        cycle(1, 8'h55, 0, 1);
        check("rst_mid_data", cmd_data, 32'h0);
        check("rst_mid_state", dbg_state == IDLE, 1'b1);
        clear_counts();
        cycle(1, 8'h01, 0, 0);
        check("rst_then_arm", arm, 1'b1);
        cycle(0, 8'h00, 0, 0);
        check("arm_one_cycle", n_arm, 1);

`ifdef SUMP_CMD_TIMEOUT_EN
        clear_counts();
        cycle(1, 8'hC0, 0, 0);
        cycle(1, 8'h11, 0, 0);
        repeat (20) cycle(0, 8'h00, 0, 0);
        check("to_proto", n_proto, 1);
        check("to_no_valid", n_cmd_valid, 0);
        check("to_keep_data", cmd_data, 32'h0);
        cycle(1, 8'h02, 0, 0);
        check("to_then_id", begin_meta_transmit, 1'b1);
        check("to_then_sid", send_id, 1'b1);
        repeat (3) cycle(0, 8'h00, 0, 0);
`endif

        // Randomized traffic against the model
        begin
            logic       v, b, r;
            logic [7:0] d;
            int         sel;
            b = 0;
            for (int i = 0; i < 3000; i++) begin
                v = ($urandom_range(0, 1) == 1);
                sel = $urandom_range(0, 9);
                if (sel < 4) d = pick[$urandom_range(0, 5)];
                else if (sel < 6) d = 8'h80 | 8'($urandom_range(0, 127));
                else d = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) b = ~b;
                r = ($urandom_range(0, 299) == 0);
                cycle(v, d, b, r);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
